exec_sequencer: RTL and testbench

- Multi-cycle controller in front of the shared 64-bit ALU (control/a/b/ans/overflow) in the SEQ execute stage.
- Accepts one decoded instruction per valid/ready handshake and selects ALU operands and control per icode/ifun.
- Owns the architectural condition-code register (ZF/SF/OF) and evaluates cnd for jXX/cmovXX.
- Returns valE/cnd to the memory stage over a second valid/ready handshake.

---
 rtl/exec_sequencer.sv | 123 ++++++++++++
 tb/tb_exec_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// exec_sequencer: SEQ execute-stage controller sequencing a shared ALU, owning CC and cnd.
// Optional EXEC_SEQ_PERF_EN adds saturating retired/stall counters.
module exec_sequencer #(
  parameter int W = 64,
  parameter int STACK_STEP = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  output logic [1:0]   alu_control,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_ans,
  input  logic         alu_overflow,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] valE,
  output logic         cnd,
  output logic         err,
  output logic [2:0]   cc
`ifdef EXEC_SEQ_PERF_EN
  ,
  output logic [31:0]  perf_retired,
  output logic [31:0]  perf_stall
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic [3:0] ic, fn;
  logic [1:0] ctl_n;
  logic [W-1:0] a_n, b_n;
  logic zf, sf, ovf, lt, cond, bad, is_cond;
  assign {zf, sf, ovf} = cc;
  assign lt = sf ^ ovf;
  assign is_cond = (ic == 4'h2) || (ic == 4'h7);
  assign bad = (ic > 4'hB) || (ic == 4'h6 && fn > 4'h3) || (is_cond && fn > 4'h6);
  always_comb begin
    ctl_n = 2'b00;
    a_n = '0;
    b_n = '0;
    case (icode)
      4'h2: a_n = valA;
      4'h3: a_n = valC;
      4'h4, 4'h5: begin a_n = valB; b_n = valC; end
      4'h6: begin ctl_n = ifun[1:0]; a_n = valB; b_n = valA; end
      4'h8, 4'hA: begin a_n = valB; b_n = -W'(STACK_STEP); end
      4'h9, 4'hB: begin a_n = valB; b_n = W'(STACK_STEP); end
      default: ;
    endcase
  end
  always_comb begin
    case (fn)
      4'h0: cond = 1'b1;
      4'h1: cond = lt | zf;
      4'h2: cond = lt;
      4'h3: cond = zf;
      4'h4: cond = !zf;
      4'h5: cond = !lt;
      4'h6: cond = !lt && !zf;
      default: cond = 1'b0;
    endcase
  end
  // cnd reads cc before this instruction's own update lands on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      valE <= '0;
      cnd <= 1'b0;
      err <= 1'b0;
      alu_control <= 2'b00;
      alu_a <= '0;
      alu_b <= '0;
      cc <= 3'b100;
      ic <= '0;
      fn <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ic <= icode;
          fn <= ifun;
          alu_control <= ctl_n;
          alu_a <= a_n;
          alu_b <= b_n;
          in_ready <= 1'b0;
          state <= EXEC;
        end
        EXEC: begin
          valE <= bad ? '0 : alu_ans;
          cnd <= !bad && is_cond && cond;
          err <= bad;
          if (!bad && ic == 4'h6) cc <= {alu_ans == '0, alu_ans[W-1], alu_overflow};
          out_valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef EXEC_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_retired <= '0;
      perf_stall <= '0;
    end else if (state == RESP) begin
      if (out_ready && perf_retired != '1) perf_retired <= perf_retired + 32'd1;
      if (!out_ready && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: vector table, reset-in-flight sequence and randomized run against a flag-level model.
module tb_exec_sequencer;
  localparam int STEP = 8;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, cnd, err, alu_overflow;
  logic [3:0] icode = 0, ifun = 0;
  logic [63:0] valA = 0, valB = 0, valC = 0, alu_a, alu_b, alu_ans, valE;
  logic [1:0] alu_control;
  logic [2:0] cc;
  int total = 0, bad = 0;

  exec_sequencer #(.W(64), .STACK_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ans(alu_ans), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .valE(valE), .cnd(cnd), .err(err), .cc(cc)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_control)
      2'b00: alu_ans = alu_a + alu_b;
      2'b01: alu_ans = alu_a - alu_b;
      2'b10: alu_ans = alu_a & alu_b;
      default: alu_ans = alu_a ^ alu_b;
    endcase
    alu_overflow = alu_control == 2'b00 ? (alu_a[63] == alu_b[63] && alu_ans[63] != alu_a[63]) :
                   alu_control == 2'b01 ? (alu_a[63] != alu_b[63] && alu_ans[63] != alu_a[63]) : 1'b0;
  end

  task automatic chk(input string n, input logic [63:0] g, input logic [63:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, g, e);
    end
  endtask

  task automatic model(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c, inout logic [2:0] mcc,
                       output logic [63:0] e, output logic mc, output logic me);
    logic signed [65:0] s;
    logic z, n, o, less;
    z = mcc[2]; n = mcc[1]; o = mcc[0];
    less = (n != o);
    me = ic > 11 || (ic == 6 && fn > 3) || ((ic == 2 || ic == 7) && fn > 6);
    e = 0; mc = 0;
    if (!me) begin
      case (ic)
        2: e = a;
        3: e = c;
        4, 5: e = b + c;
        8, 10: e = b - STEP;
        9, 11: e = b + STEP;
        6: begin
          o = 0;
          if (fn == 0) s = $signed(b) + $signed(a);
          else if (fn == 1) s = $signed(b) - $signed(a);
          if (fn <= 1) begin e = s[63:0]; o = (s != {{2{s[63]}}, s[63:0]}); end
          else e = (fn == 2) ? (b & a) : (b ^ a);
          mcc = {e == 0, e[63], o};
        end
        default: e = 0;
      endcase
      if (ic == 2 || ic == 7)
        mc = fn == 0 ? 1'b1 : fn == 1 ? (less || z) : fn == 2 ? less : fn == 3 ? z :
             fn == 4 ? !z : fn == 5 ? !less : (!less && !z);
    end
  endtask

  task automatic xact(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] c, input int hold,
                      output logic [63:0] re, output logic rc, output logic rr, output logic [2:0] rcc);
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    icode = ic; ifun = fn; valA = a; valB = b; valC = c; in_valid = 1; out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    chk("exec_out_valid", out_valid, 0);
    chk("exec_in_ready", in_ready, 0);
    @(negedge clk);
    chk("resp_out_valid", out_valid, 1);
    re = valE; rc = cnd; rr = err; rcc = cc;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("stall_valE", valE, re);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
  endtask

  function automatic logic [63:0] rv();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'($urandom_range(0, 16));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  typedef struct {
    logic [3:0] ic, fn;
    logic [63:0] a, b, c, e;
    logic cn, er;
    logic [2:0] cc;
    int hold;
  } vec_t;
  vec_t tbl[22];

  initial begin
    logic [63:0] ge, me;
    logic gc, gr, mc, mr;
    logic [2:0] gcc, mcc;
    tbl[0]  = '{4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 64'd0, 1'b0, 1'b0, 3'b100, 0};
    tbl[1]  = '{4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 3'b011, 0};
    tbl[2]  = '{4'h7, 4'h2, 64'd9, 64'd9, 64'd9, 64'd0, 1'b0, 1'b0, 3'b011, 1};
    tbl[3]  = '{4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 64'hF8, 1'b0, 1'b0, 3'b011, 0};
    tbl[4]  = '{4'hB, 4'h0, 64'd0, 64'hF8, 64'd0, 64'h100, 1'b0, 1'b0, 3'b011, 0};
    tbl[5]  = '{4'h5, 4'h0, 64'd0, 64'h40, 64'h8, 64'h48, 1'b0, 1'b0, 3'b011, 4};
    tbl[6]  = '{4'hC, 4'h0, 64'd3, 64'd3, 64'd3, 64'd0, 1'b0, 1'b1, 3'b011, 0};
    tbl[7]  = '{4'h2, 4'h7, 64'h55, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 3'b011, 0};
    tbl[8]  = '{4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 64'h1234, 1'b0, 1'b0, 3'b011, 0};
    tbl[9]  = '{4'h6, 4'h2, 64'hF0, 64'h3C, 64'd0, 64'h30, 1'b0, 1'b0, 3'b000, 0};
    tbl[10] = '{4'h7, 4'h1, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 3'b000, 0};
    tbl[11] = '{4'h6, 4'h3, 64'hAB, 64'hAB, 64'd0, 64'd0, 1'b0, 1'b0, 3'b100, 0};
    tbl[12] = '{4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 3'b100, 0};
    tbl[13] = '{4'h2, 4'h3, 64'h77, 64'd0, 64'd0, 64'h77, 1'b1, 1'b0, 3'b100, 0};
    tbl[14] = '{4'h6, 4'h5, 64'd1, 64'd2, 64'd0, 64'd0, 1'b0, 1'b1, 3'b100, 0};
    tbl[15] = '{4'h8, 4'h0, 64'd0, 64'h10, 64'd0, 64'h8, 1'b0, 1'b0, 3'b100, 0};
    tbl[16] = '{4'h6, 4'h1, 64'd1, 64'd0, 64'd0, '1, 1'b0, 1'b0, 3'b010, 0};
    tbl[17] = '{4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 3'b010, 0};
    tbl[18] = '{4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 3'b010, 0};
    tbl[19] = '{4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 3'b010, 0};
    tbl[20] = '{4'h1, 4'h0, 64'd4, 64'd4, 64'd4, 64'd0, 1'b0, 1'b0, 3'b010, 0};
    tbl[21] = '{4'h0, 4'h0, 64'd4, 64'd4, 64'd4, 64'd0, 1'b0, 1'b0, 3'b010, 0};

    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_valE", valE, 0);
    chk("rst_cnd", cnd, 0);
    chk("rst_err", err, 0);
    chk("rst_cc", cc, 3'b100);
    chk("rst_alu_control", alu_control, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);

    for (int i = 0; i < 22; i++) begin
      xact(tbl[i].ic, tbl[i].fn, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].hold, ge, gc, gr, gcc);
      chk($sformatf("vec%0d_valE", i), ge, tbl[i].e);
      chk($sformatf("vec%0d_cnd", i), gc, tbl[i].cn);
      chk($sformatf("vec%0d_err", i), gr, tbl[i].er);
      chk($sformatf("vec%0d_cc", i), gcc, tbl[i].cc);
    end

    xact(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 0, ge, gc, gr, gcc);
    chk("pre_rst_cc", gcc, 3'b011);
    @(negedge clk);
    icode = 4'h6; ifun = 4'h0; valA = 64'd1; valB = 64'd1; in_valid = 1;
    @(negedge clk);
    in_valid = 0; rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_cc", cc, 3'b100);
    chk("midrst_valE", valE, 0);
    out_ready = 1;
    repeat (2) @(negedge clk);
    chk("midrst_no_result", out_valid, 0);
    out_ready = 0;

    mcc = 3'b100;
    for (int i = 0; i < 200; i++) begin
      logic [3:0] ic, fn;
      logic [63:0] a, b, c;
      ic = 4'($urandom_range(0, 15));
      fn = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      a = rv(); b = rv(); c = rv();
      model(ic, fn, a, b, c, mcc, me, mc, mr);
      xact(ic, fn, a, b, c, $urandom_range(0, 2), ge, gc, gr, gcc);
      chk($sformatf("rnd%0d_valE ic=%h fn=%h", i, ic, fn), ge, me);
      chk($sformatf("rnd%0d_cnd ic=%h fn=%h", i, ic, fn), gc, mc);
      chk($sformatf("rnd%0d_err ic=%h fn=%h", i, ic, fn), gr, mr);
      chk($sformatf("rnd%0d_cc ic=%h fn=%h", i, ic, fn), gcc, mcc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
